// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC write scheduler.
//   CMD_WRITE : command nibble placed in the top byte of every DAC write
//   state_e   : scheduler FSM encoding
package dac_sched_pkg;

    localparam logic [3:0] CMD_WRITE = 4'h3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StSettle
    } state_e;

endpackage

// File: rtl/dac_write_scheduler_if.sv
// I2C write command bus between the DAC write scheduler and the I2C master.
//   i2c_start : one-cycle launch pulse (scheduler -> master)
//   i2c_addr  : 7-bit device address, held until done/err
//   i2c_data  : command byte + 16-bit data word, held until done/err
//   i2c_busy  : master busy
//   i2c_done  : one-cycle pulse, write acknowledged
//   i2c_err   : one-cycle pulse, NACK or bus error
interface dac_write_scheduler_if;

    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [23:0] i2c_data;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_err;

    modport master (
        output i2c_start, i2c_addr, i2c_data,
        input  i2c_busy, i2c_done, i2c_err
    );

    modport slave (
        input  i2c_start, i2c_addr, i2c_data,
        output i2c_busy, i2c_done, i2c_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder.
//   req   : request vector, one bit per channel
//   ptr   : channel index where the search starts (must be < NUM_CH)
//   idx   : first requesting channel at or after ptr, wrapping
//   valid : 1 when any request is set
module rr_pick #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [3:0]        ptr,
    output logic [3:0]        idx,
    output logic              valid
);

    logic [NUM_CH-1:0] rot;
    logic [NUM_CH-1:0] probe;

    always_comb begin
        // Rotate so that channel ptr lands on bit 0.
        rot   = NUM_CH'({req, req} >> ptr);
        idx   = '0;
        valid = 1'b0;
        probe = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            probe = rot >> i;
            if (!valid && probe[0]) begin
                valid = 1'b1;
                idx   = 4'((32'(ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/dac_write_scheduler.sv
// Shares one I2C DAC write path between NUM_CH channels. Channels whose requested code differs
// from the last code written are granted round-robin; each grant issues one write, retried on
// error/timeout up to MAX_RETRY times, followed by a SETTLE_CYCLES holdoff.
//   clk_in, reset_in : clock, asynchronous active-high reset
//   ch_vol           : requested code per channel, channel k at [k*VOL_W +: VOL_W]
//   ch_enable        : channel participates when 1
//   hold             : blocks new grants; an in-flight write still completes
//   i2c              : write command bus to the I2C master
//   ch_ack           : one-cycle pulse on the channel whose write completed
//   settled          : idle with nothing pending
//   err_count        : saturating count of dropped writes
//   last_ch          : most recently granted channel
module dac_write_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned VOL_W          = 12,
    parameter logic [6:0]  DAC_ADDR       = 7'h60,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [NUM_CH*VOL_W-1:0]   ch_vol,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic                      hold,
    dac_write_scheduler_if.master     i2c,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic                      settled,
    output logic [7:0]                err_count,
    output logic [3:0]                last_ch
);

    localparam int unsigned VEC_W   = NUM_CH * VOL_W;
    localparam int unsigned TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [VEC_W-1:0] LANE = VEC_W'({VOL_W{1'b1}});

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [3:0]          rr_ptr_q, rr_ptr_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [VOL_W-1:0]    snap_q, snap_d;
    logic [23:0]         data_q, data_d;
    logic [VEC_W-1:0]    written_q, written_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic [7:0]          err_q, err_d;
    logic [3:0]          last_q, last_d;
    logic                eval_q;

    logic [NUM_CH-1:0]   pending;
    logic [3:0]          pick_idx;
    logic                pick_valid;
    logic [VOL_W-1:0]    pick_vol;
    logic [15:0]         pick_word;
    logic [3:0]          ptr_next;
    logic [VEC_W-1:0]    lane_sh;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pending
        assign pending[k] = ch_enable[k] &&
                            (ch_vol[k*VOL_W +: VOL_W] != written_q[k*VOL_W +: VOL_W]);
    end

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req   (pending),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_vol  = VOL_W'(ch_vol >> (32'(pick_idx) * VOL_W));
    // Code is left-justified in the 16-bit data word.
    assign pick_word = 16'(pick_vol) << (16 - VOL_W);
    assign ptr_next  = (gnt_q == 4'(NUM_CH - 1)) ? 4'd0 : gnt_q + 4'd1;
    assign lane_sh   = 32'(gnt_q) * VOL_W;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        snap_d    = snap_q;
        data_d    = data_q;
        written_d = written_q;
        ch_ack_d  = '0;
        err_d     = err_q;
        last_d    = last_q;
        unique case (state_q)
            StIdle: begin
                if (!hold && !i2c.i2c_busy && pick_valid) begin
                    gnt_d   = pick_idx;
                    snap_d  = pick_vol;
                    data_d  = {CMD_WRITE, pick_idx, pick_word};
                    state_d = StStart;
                end
            end
            StStart: begin
                last_d  = gnt_q;
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // Error takes priority over a simultaneous done.
                if (i2c.i2c_err || timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StStart;
                    end else begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        retry_d  = '0;
                        rr_ptr_d = ptr_next;
                        timer_d  = '0;
                        state_d  = StSettle;
                    end
                end else if (i2c.i2c_done) begin
                    written_d = (written_q & ~(LANE << lane_sh)) | (VEC_W'(snap_q) << lane_sh);
                    ch_ack_d  = NUM_CH'(1) << gnt_q;
                    retry_d   = '0;
                    rr_ptr_d  = ptr_next;
                    timer_d   = '0;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            retry_q   <= '0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            snap_q    <= '0;
            data_q    <= '0;
            written_q <= '0;
            ch_ack_q  <= '0;
            err_q     <= '0;
            last_q    <= '0;
            eval_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            snap_q    <= snap_d;
            data_q    <= data_d;
            written_q <= written_d;
            ch_ack_q  <= ch_ack_d;
            err_q     <= err_d;
            last_q    <= last_d;
            eval_q    <= 1'b1;
        end
    end

    assign i2c.i2c_start = (state_q == StStart);
    assign i2c.i2c_addr  = DAC_ADDR;
    assign i2c.i2c_data  = data_q;
    assign ch_ack        = ch_ack_q;
    // Held low until the first clock after reset has evaluated pending.
    assign settled       = eval_q && (state_q == StIdle) && !(|pending);
    assign err_count     = err_q;
    assign last_ch       = last_q;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Scoreboard bench for dac_write_scheduler: expected write commands and acks are queued by the
// directed stimulus; monitors pop and compare whenever the DUT issues i2c_start or ch_ack.
module tb_dac_write_scheduler;

    localparam int unsigned SETTLE  = 20;
    localparam int unsigned TIMEOUT = 100;

    typedef enum int {RDone, RErr, RNone} rkind_e;
    typedef struct {
        rkind_e kind;
        int     lat;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][11:0] vols;
    logic [3:0]       en;
    logic             hold;
    logic [3:0]       ch_ack;
    logic             settled;
    logic [7:0]       err_count;
    logic [3:0]       last_ch;

    dac_write_scheduler_if bus();

    dac_write_scheduler #(
        .NUM_CH         (4),
        .VOL_W          (12),
        .DAC_ADDR       (7'h60),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRY      (2)
    ) dut (
        .clk_in    (clk),
        .reset_in  (rst),
        .ch_vol    (vols),
        .ch_enable (en),
        .hold      (hold),
        .i2c       (bus),
        .ch_ack    (ch_ack),
        .settled   (settled),
        .err_count (err_count),
        .last_ch   (last_ch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cnt = 0;
    int ack_cyc = 0;
    int start_cyc[$];
    logic [23:0] exp_q[$];
    logic [3:0]  ack_q[$];
    resp_t       resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vol(input logic [1:0] ch, input logic [11:0] v);
        vols[ch] = v;
    endtask

    task automatic expect_write(input logic [23:0] data, input rkind_e kind, input int lat);
        resp_t r;
        r.kind = kind;
        r.lat  = lat;
        exp_q.push_back(data);
        resp_q.push_back(r);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(settled && exp_q.size() == 0 && ack_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: not idle after %0d cycles, %0d writes outstanding", name, n,
                     exp_q.size());
        end
    endtask

    task automatic wait_start(input string name, input int n0, input int budget);
        int n = 0;
        while (start_cnt <= n0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: no i2c_start within %0d cycles", name, budget);
        end
    endtask

    // I2C master model: busy for lat cycles after a start, then the scripted pulse.
    initial begin
        resp_t r;
        bus.i2c_busy = 1'b0;
        bus.i2c_done = 1'b0;
        bus.i2c_err  = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_done = 1'b0;
            bus.i2c_err  = 1'b0;
            if (!rst && bus.i2c_start) begin
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                end else begin
                    r.kind = RDone;
                    r.lat  = 3;
                end
                bus.i2c_busy = 1'b1;
                repeat (r.lat) @(negedge clk);
                bus.i2c_busy = 1'b0;
                if (r.kind == RDone) bus.i2c_done = 1'b1;
                else if (r.kind == RErr) bus.i2c_err = 1'b1;
            end
        end
    end

    // Write-command monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.i2c_start) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got data %06h, no write expected",
                             bus.i2c_data);
                end else begin
                    chk("start_data", 32'(bus.i2c_data), 32'(exp_q.pop_front()));
                    chk("start_addr", 32'(bus.i2c_addr), 32'h60);
                end
            end
        end
    end

    // Ack monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ch_ack != 4'b0) begin
                ack_cyc = cyc;
                if (ack_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got %b, no ack expected", ch_ack);
                end else begin
                    chk("ch_ack", 32'(ch_ack), 32'(ack_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int idx;
        int gap;
        int n;
        rst  = 1'b1;
        vols = '0;
        en   = 4'hF;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", 32'(bus.i2c_start), 32'h0);
        chk("rst_addr", 32'(bus.i2c_addr), 32'h60);
        chk("rst_data", 32'(bus.i2c_data), 32'h0);
        chk("rst_ack", 32'(ch_ack), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_last", 32'(last_ch), 32'h0);
        chk("rst_settled", 32'(settled), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_settled", 32'(settled), 32'h1);

        // Single write on ch2, code 750, done 10 cycles after start.
        expect_write(24'h322EE0, RDone, 10);
        ack_q.push_back(4'b0100);
        set_vol(2'd2, 12'd750);
        wait_idle("single", 200);
        chk("settle_len", 32'(cyc - ack_cyc), SETTLE);
        chk("single_last", 32'(last_ch), 32'h2);

        // rr_ptr = 3: ch0 is granted, leaving rr_ptr = 1.
        expect_write(24'h301230, RDone, 3);
        ack_q.push_back(4'b0001);
        set_vol(2'd0, 12'h123);
        wait_idle("to_ptr1", 200);

        // All four change with rr_ptr = 1 -> 1,2,3,0.
        idx = start_cyc.size();
        expect_write(24'h310010, RDone, 3);
        expect_write(24'h32FFF0, RDone, 3);
        expect_write(24'h338000, RDone, 3);
        expect_write(24'h304560, RDone, 3);
        ack_q.push_back(4'b0010);
        ack_q.push_back(4'b0100);
        ack_q.push_back(4'b1000);
        ack_q.push_back(4'b0001);
        set_vol(2'd0, 12'h456);
        set_vol(2'd1, 12'h001);
        set_vol(2'd2, 12'hFFF);
        set_vol(2'd3, 12'h800);
        wait_idle("rr4", 600);
        for (int i = 1; i < 4; i++) begin
            gap = start_cyc[idx + i] - start_cyc[idx + i - 1];
            // START + 3 busy cycles + settle + IDLE
            chk("rr_gap_ok", 32'(gap >= int'(SETTLE) + 5), 32'h1);
        end

        // ch0 errors on every attempt: 3 starts, drop, ch1 next, then ch0 again.
        for (int i = 0; i < 3; i++) expect_write(24'h300AA0, RErr, 2);
        expect_write(24'h310BB0, RDone, 3);
        expect_write(24'h300AA0, RDone, 3);
        ack_q.push_back(4'b0010);
        ack_q.push_back(4'b0001);
        n = start_cnt;
        set_vol(2'd0, 12'h0AA);
        wait_start("err_first", n, 50);
        set_vol(2'd1, 12'h0BB);
        wait_idle("err_retry", 600);
        chk("err_count1", 32'(err_count), 32'h1);
        chk("err_last", 32'(last_ch), 32'h0);

        // No response on ch3: retries every TIMEOUT, drop after the third, then succeed.
        idx = start_cyc.size();
        for (int i = 0; i < 3; i++) expect_write(24'h333210, RNone, 4);
        expect_write(24'h333210, RDone, 2);
        ack_q.push_back(4'b1000);
        set_vol(2'd3, 12'h321);
        wait_idle("timeout", 1000);
        for (int i = 1; i < 3; i++) begin
            gap = start_cyc[idx + i] - start_cyc[idx + i - 1];
            chk("timeout_gap_ok", 32'(gap >= int'(TIMEOUT) && gap <= int'(TIMEOUT) + 1), 32'h1);
        end
        chk("err_count2", 32'(err_count), 32'h2);

        // hold blocks a new grant; hold raised during WAIT still completes the write.
        hold = 1'b1;
        n = start_cnt;
        set_vol(2'd1, 12'h777);
        repeat (30) @(negedge clk);
        chk("hold_nostart", 32'(start_cnt), 32'(n));
        chk("hold_settled", 32'(settled), 32'h0);
        expect_write(24'h317770, RDone, 8);
        ack_q.push_back(4'b0010);
        hold = 1'b0;
        wait_start("hold_release", n, 10);
        repeat (2) @(negedge clk);
        hold = 1'b1;
        n = 0;
        while (ack_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("hold_ack_done", 32'(ack_q.size()), 32'h0);
        hold = 1'b0;
        wait_idle("hold", 100);
        chk("hold_last", 32'(last_ch), 32'h1);

        // Reset pulsed during WAIT.
        expect_write(24'h321000, RNone, 40);
        n = start_cnt;
        set_vol(2'd2, 12'h100);
        wait_start("rst_wait", n, 20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_start", 32'(bus.i2c_start), 32'h0);
        chk("rstw_err", 32'(err_count), 32'h0);
        chk("rstw_last", 32'(last_ch), 32'h0);
        chk("rstw_data", 32'(bus.i2c_data), 32'h0);
        vols = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_settled", 32'(settled), 32'h1);
        n = 0;
        while (bus.i2c_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("final_start_idle", 32'(bus.i2c_start), 32'h0);
        chk("final_exp_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
